// File: rtl/scan_host_if.sv
// Harness-side bus of scan_host: command, byte streams and status.
// Handshakes (cmd, tx, rx): a transfer happens on the rising clk edge where valid && ready are both high; valid never waits on ready.
interface scan_host_if;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] run_cycles;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        halted;

    modport master (
        output cmd, cmd_valid, run_cycles, tx_data, tx_valid, rx_ready,
        input  cmd_ready, tx_ready, rx_data, rx_valid, busy, halted
    );

    modport slave (
        input  cmd, cmd_valid, run_cycles, tx_data, tx_valid, rx_ready,
        output cmd_ready, tx_ready, rx_data, rx_valid, busy, halted
    );
endinterface

// File: rtl/scan_host.sv
// Host-side driver for the qtcore scan/run pins: scans a byte stream through the chain, runs to halt, pulses target reset.
// Optional feature macro: SCAN_HOST_READBACK_EN enables capture of the old chain contents onto the rx stream.
module scan_host #(
    parameter int CHAIN_LEN = 144,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    scan_host_if.slave  bus,
    output logic        tgt_clk,
    output logic        tgt_rst,
    output logic        tgt_scan_en_n,
    output logic        tgt_proc_en_n,
    output logic        tgt_mosi,
    input  logic        tgt_miso,
    output logic [2:0]  dbg_state
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] CHAIN_BITS = BW'(CHAIN_LEN);
    localparam logic [1:0] CMD_SCAN   = 2'd0;
    localparam logic [1:0] CMD_RUN    = 2'd1;
    localparam logic [1:0] CMD_TRESET = 2'd2;
    localparam logic [1:0] CMD_STEP   = 2'd3;

    typedef enum logic [2:0] {
        IDLE, SC_FETCH, SC_LOW, SC_HIGH, SC_PUSH, RN_LOW, RN_HIGH, TR
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [BW-1:0]  bits_q, bits_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     tx_sh_q, tx_sh_d;
    logic [15:0]    run_lim_q, run_lim_d;
    logic [15:0]    run_cnt_q, run_cnt_d;
    logic [1:0]     ph_q, ph_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           busy_q, busy_d;
    logic           halted_q, halted_d;
    logic           tx_ready_q, tx_ready_d;
    logic           tgt_clk_q, tgt_clk_d;
    logic           tgt_rst_q, tgt_rst_d;
    logic           scan_en_n_q, scan_en_n_d;
    logic           proc_en_n_q, proc_en_n_d;
    logic           mosi_q, mosi_d;
`ifdef SCAN_HOST_READBACK_EN
    logic [7:0]     rx_sh_q, rx_sh_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
`endif

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bits_d      = bits_q;
        idx_d       = idx_q;
        tx_sh_d     = tx_sh_q;
        run_lim_d   = run_lim_q;
        run_cnt_d   = run_cnt_q;
        ph_d        = ph_q;
        halted_d    = halted_q;
        tgt_clk_d   = tgt_clk_q;
        tgt_rst_d   = tgt_rst_q;
        scan_en_n_d = scan_en_n_q;
        proc_en_n_d = proc_en_n_q;
        mosi_d      = mosi_q;
`ifdef SCAN_HOST_READBACK_EN
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    halted_d = 1'b0;
                    div_d    = '0;
                    case (bus.cmd)
                        CMD_SCAN: begin
                            state_d     = SC_FETCH;
                            scan_en_n_d = 1'b0;
                            bits_d      = CHAIN_BITS;
                            idx_d       = 3'd0;
                        end
                        CMD_RUN, CMD_STEP: begin
                            state_d     = RN_LOW;
                            proc_en_n_d = 1'b0;
                            run_lim_d   = (bus.cmd == CMD_STEP) ? 16'd1 : bus.run_cycles;
                            run_cnt_d   = 16'd0;
                        end
                        CMD_TRESET: begin
                            state_d   = TR;
                            tgt_rst_d = 1'b1;
                            ph_d      = 2'd0;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            // tgt_clk is parked low here, so a tx stall can last forever without corrupting the chain
            SC_FETCH: begin
                if (bus.tx_valid) begin
                    tx_sh_d = bus.tx_data;
                    mosi_d  = bus.tx_data[0];
                    idx_d   = 3'd0;
                    div_d   = '0;
                    state_d = SC_LOW;
                end
            end
            SC_LOW: begin
                if (div_q == DIV_LAST) begin
`ifdef SCAN_HOST_READBACK_EN
                    rx_sh_d = {tgt_miso, rx_sh_q[7:1]};
`endif
                    tgt_clk_d = 1'b1;
                    div_d     = '0;
                    state_d   = SC_HIGH;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SC_HIGH: begin
                if (div_q == DIV_LAST) begin
                    tgt_clk_d = 1'b0;
                    div_d     = '0;
                    bits_d    = bits_q - BW'(1);
                    idx_d     = idx_q + 3'd1;
                    tx_sh_d   = tx_sh_q >> 1;
                    if (bits_q == BW'(1) || idx_q == 3'd7) begin
`ifdef SCAN_HOST_READBACK_EN
                        // Captured bits sit at the top of rx_sh; right-align so a short last byte has zero upper bits
                        rx_data_d = rx_sh_q >> (3'd7 - idx_q);
                        state_d   = SC_PUSH;
`else
                        if (bits_q == BW'(1)) begin
                            state_d     = IDLE;
                            scan_en_n_d = 1'b1;
                        end else begin
                            state_d = SC_FETCH;
                        end
`endif
                    end else begin
                        mosi_d  = tx_sh_q[1];
                        state_d = SC_LOW;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SC_PUSH: begin
                if (bus.rx_ready) begin
                    if (bits_q == '0) begin
                        state_d     = IDLE;
                        scan_en_n_d = 1'b1;
                    end else begin
                        state_d = SC_FETCH;
                    end
                end
            end
            RN_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (tgt_miso) begin
                        halted_d    = 1'b1;
                        proc_en_n_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        tgt_clk_d = 1'b1;
                        run_cnt_d = run_cnt_q + 16'd1;
                        state_d   = RN_HIGH;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            RN_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    tgt_clk_d = 1'b0;
                    if (run_lim_q != 16'd0 && run_cnt_q == run_lim_q) begin
                        proc_en_n_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = RN_LOW;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            // Four CLK_DIV-long phases: low, high, low, high -> two full target clock periods
            TR: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (ph_q == 2'd3) begin
                        tgt_rst_d = 1'b0;
                        tgt_clk_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        ph_d      = ph_q + 2'd1;
                        tgt_clk_d = ~tgt_clk_q;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            mosi_d = 1'b0;
        end

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        tx_ready_d  = (state_d == SC_FETCH);
`ifdef SCAN_HOST_READBACK_EN
        rx_valid_d  = (state_d == SC_PUSH);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bits_q      <= '0;
            idx_q       <= '0;
            tx_sh_q     <= '0;
            run_lim_q   <= '0;
            run_cnt_q   <= '0;
            ph_q        <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            tx_ready_q  <= 1'b0;
            tgt_clk_q   <= 1'b0;
            tgt_rst_q   <= 1'b0;
            scan_en_n_q <= 1'b1;
            proc_en_n_q <= 1'b1;
            mosi_q      <= 1'b0;
`ifdef SCAN_HOST_READBACK_EN
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bits_q      <= bits_d;
            idx_q       <= idx_d;
            tx_sh_q     <= tx_sh_d;
            run_lim_q   <= run_lim_d;
            run_cnt_q   <= run_cnt_d;
            ph_q        <= ph_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            tx_ready_q  <= tx_ready_d;
            tgt_clk_q   <= tgt_clk_d;
            tgt_rst_q   <= tgt_rst_d;
            scan_en_n_q <= scan_en_n_d;
            proc_en_n_q <= proc_en_n_d;
            mosi_q      <= mosi_d;
`ifdef SCAN_HOST_READBACK_EN
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.tx_ready  = tx_ready_q;
`ifdef SCAN_HOST_READBACK_EN
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
`else
    logic unused_rx_ready;
    assign unused_rx_ready = bus.rx_ready;
    assign bus.rx_valid    = 1'b0;
    assign bus.rx_data     = 8'h00;
`endif

    assign tgt_clk       = tgt_clk_q;
    assign tgt_rst       = tgt_rst_q;
    assign tgt_scan_en_n = scan_en_n_q;
    assign tgt_proc_en_n = proc_en_n_q;
    assign tgt_mosi      = mosi_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_scan_host.sv
// Bench for scan_host: a target model (shift chain + halt source) on the pins, random byte streams, stalls and run limits.
module tb_scan_host;
    localparam int CL = 20;
    localparam int CD = 2;
    localparam int NB = (CL + 7) / 8;
`ifdef SCAN_HOST_READBACK_EN
    localparam int SCAN_CYC = CL * 2 * CD + 2 * NB;
`else
    localparam int SCAN_CYC = CL * 2 * CD + NB;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_host_if bus ();
    logic       tgt_clk, tgt_rst, tgt_scan_en_n, tgt_proc_en_n, tgt_mosi, tgt_miso;
    logic [2:0] dbg_state;

    scan_host #(.CHAIN_LEN(CL), .CLK_DIV(CD)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .tgt_clk(tgt_clk), .tgt_rst(tgt_rst), .tgt_scan_en_n(tgt_scan_en_n),
        .tgt_proc_en_n(tgt_proc_en_n), .tgt_mosi(tgt_mosi), .tgt_miso(tgt_miso),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    // ---------------- target model ----------------
    logic [CL-1:0] tchain = CL'(32'h3C5A7);
    logic prev_tclk = 1'b0;
    int   edges_all = 0;
    int   proc_edges = 0;
    int   excl_viol = 0;
    int   run_base = 0;
    int   halt_after = 0;
    bit   halt_en = 1'b0;

    always @(negedge clk) begin
        if (tgt_clk === 1'b1 && prev_tclk === 1'b0) begin
            edges_all++;
            if (tgt_scan_en_n === 1'b0) tchain = {tgt_mosi, tchain[CL-1:1]};
            if (tgt_proc_en_n === 1'b0) proc_edges++;
        end
        if (tgt_scan_en_n === 1'b0 && tgt_proc_en_n === 1'b0) excl_viol++;
        prev_tclk = tgt_clk;
    end

    assign tgt_miso = (tgt_scan_en_n === 1'b0) ? tchain[0] :
                      ((tgt_proc_en_n === 1'b0) && halt_en && ((proc_edges - run_base) >= halt_after));

    // ---------------- scoreboard state ----------------
    logic [7:0] tx_b [NB];
    logic [7:0] got_rx_q [$];
    logic [7:0] exp_q [$];
    int busy_cyc, stall_clk_hi, both_hi, rx_seen, tx_taken;

    function automatic logic [7:0] exp_rx_byte(input logic [CL-1:0] old, input int k);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 8; b++) if (8 * k + b < CL) r[b] = old[8 * k + b];
        return r;
    endfunction

    function automatic logic [CL-1:0] exp_chain();
        logic [CL-1:0] c;
        for (int b = 0; b < CL; b++) c[b] = tx_b[b / 8][b % 8];
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] c, input logic [15:0] rc);
        int w;
        w = 0;
        bus.cmd = c;
        bus.run_cycles = rc;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && w < 200) begin
            tick();
            w++;
        end
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%0b required=1", bus.cmd_ready);
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drive_scan(input int tx_stall_byte, input int tx_stall_len,
                              input int rx_stall_byte, input int rx_stall_len);
        int ri, ts, rs, cyc;
        ri = 0; ts = 0; rs = 0; cyc = 0;
        got_rx_q.delete();
        busy_cyc = 0; stall_clk_hi = 0; both_hi = 0; rx_seen = 0; tx_taken = 0;
        issue_cmd(2'd0, 16'd0);
        while (bus.busy && cyc < 5000) begin
            bus.tx_valid = 1'b0;
            bus.rx_ready = 1'b0;
            if (bus.tx_ready && bus.rx_valid) both_hi++;
            if (bus.rx_valid || bus.rx_data != 8'h00) rx_seen++;
            if (bus.tx_ready) begin
                if (tx_taken == tx_stall_byte && ts < tx_stall_len) begin
                    ts++;
                    if (tgt_clk) stall_clk_hi++;
                end else begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data = (tx_taken < NB) ? tx_b[tx_taken] : 8'h00;
                    tx_taken++;
                end
            end
            if (bus.rx_valid) begin
                if (ri == rx_stall_byte && rs < rx_stall_len) begin
                    rs++;
                    if (tgt_clk) stall_clk_hi++;
                end else begin
                    bus.rx_ready = 1'b1;
                    got_rx_q.push_back(bus.rx_data);
                    ri++;
                end
            end
            busy_cyc++;
            cyc++;
            tick();
        end
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0;
        tick();
        tick();
        got = {bus.cmd_ready, bus.busy, bus.halted, bus.tx_ready, bus.rx_valid,
               tgt_clk, tgt_rst, tgt_scan_en_n, tgt_proc_en_n, tgt_mosi};
        total++;
        if (got !== 10'b1000000110) begin
            bad++;
            $display("FAIL reset_flags: got=%b required=%b", got, 10'b1000000110);
        end
        total++;
        if (bus.rx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rx_data: got=%h required=00", bus.rx_data);
        end
        total++;
        if (dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got=%0d required=0", dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_scan_result(input string name, input logic [CL-1:0] exp_c,
                                     input int e0, input int exp_cyc);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: busy=%0b required=0", name, bus.busy);
        end
        total++;
        if (tx_taken !== NB) begin
            bad++;
            $display("FAIL %s_tx_bytes: got=%0d required=%0d", name, tx_taken, NB);
        end
        total++;
        if (edges_all - e0 !== CL) begin
            bad++;
            $display("FAIL %s_edges: got=%0d required=%0d", name, edges_all - e0, CL);
        end
        total++;
        if (tchain !== exp_c) begin
            bad++;
            $display("FAIL %s_chain: got=%h required=%h", name, tchain, exp_c);
        end
        total++;
        if (busy_cyc !== exp_cyc) begin
            bad++;
            $display("FAIL %s_cycles: got=%0d required=%0d", name, busy_cyc, exp_cyc);
        end
        total++;
        if ({tgt_clk, tgt_scan_en_n, both_hi != 0} !== 3'b010) begin
            bad++;
            $display("FAIL %s_exit: clk,scan_en_n,both_hi got=%b required=010",
                     name, {tgt_clk, tgt_scan_en_n, both_hi != 0});
        end
`ifdef SCAN_HOST_READBACK_EN
        total++;
        if (got_rx_q.size() !== NB) begin
            bad++;
            $display("FAIL %s_rx_count: got=%0d required=%0d", name, got_rx_q.size(), NB);
        end
        while (exp_q.size() > 0 && got_rx_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front();
            g = got_rx_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s_rx_byte: got=%h required=%h", name, g, e);
            end
        end
`else
        total++;
        if (rx_seen !== 0) begin
            bad++;
            $display("FAIL %s_rx_idle: active cycles=%0d required=0", name, rx_seen);
        end
`endif
    endtask

    task automatic test_scan_random();
        for (int it = 0; it < 3; it++) begin
            logic [CL-1:0] old;
            int e0;
            old = tchain;
            e0 = edges_all;
            for (int k = 0; k < NB; k++) tx_b[k] = 8'($urandom_range(0, 255));
            exp_q.delete();
            for (int k = 0; k < NB; k++) exp_q.push_back(exp_rx_byte(old, k));
            drive_scan(-1, 0, -1, 0);
            check_scan_result("scan_rand", exp_chain(), e0, SCAN_CYC);
        end
    endtask

    task automatic test_partial_byte();
        logic [CL-1:0] old;
        int e0;
        old = tchain;
        e0 = edges_all;
        for (int k = 0; k < NB; k++) tx_b[k] = 8'hFF;
        exp_q.delete();
        for (int k = 0; k < NB; k++) exp_q.push_back(exp_rx_byte(old, k));
`ifdef SCAN_HOST_READBACK_EN
        drive_scan(-1, 0, -1, 0);
        total++;
        if (got_rx_q.size() == NB && (got_rx_q[NB - 1] & 8'hF0) !== 8'h00) begin
            bad++;
            $display("FAIL partial_upper_bits: got=%h required=0x", got_rx_q[NB - 1]);
        end
`else
        drive_scan(-1, 0, -1, 0);
`endif
        check_scan_result("partial", {CL{1'b1}}, e0, SCAN_CYC);
    endtask

    task automatic test_backpressure();
        logic [CL-1:0] old;
        int e0;
        old = tchain;
        e0 = edges_all;
        for (int k = 0; k < NB; k++) tx_b[k] = 8'($urandom_range(0, 255));
        exp_q.delete();
        for (int k = 0; k < NB; k++) exp_q.push_back(exp_rx_byte(old, k));
        drive_scan(1, 20, 0, 10);
        total++;
        if (stall_clk_hi !== 0) begin
            bad++;
            $display("FAIL stall_tgt_clk: high cycles=%0d required=0", stall_clk_hi);
        end
`ifdef SCAN_HOST_READBACK_EN
        check_scan_result("backpressure", exp_chain(), e0, SCAN_CYC + 30);
`else
        check_scan_result("backpressure", exp_chain(), e0, SCAN_CYC + 20);
`endif
    endtask

    task automatic test_run_halt();
        int w;
        halt_en = 1'b1;
        halt_after = 5;
        run_base = proc_edges;
        issue_cmd(2'd1, 16'd0);
        total++;
        if ({tgt_proc_en_n, tgt_scan_en_n} !== 2'b01) begin
            bad++;
            $display("FAIL run_enable: proc_n,scan_n got=%b required=01", {tgt_proc_en_n, tgt_scan_en_n});
        end
        w = 0;
        while (bus.busy && w < 2000) begin
            tick();
            w++;
        end
        total++;
        if (bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL run_halted: got=%0b required=1", bus.halted);
        end
        total++;
        if (proc_edges - run_base !== 5) begin
            bad++;
            $display("FAIL run_halt_edges: got=%0d required=5", proc_edges - run_base);
        end
        total++;
        if ({bus.busy, tgt_proc_en_n, tgt_clk} !== 3'b010) begin
            bad++;
            $display("FAIL run_halt_idle: busy,proc_n,clk got=%b required=010", {bus.busy, tgt_proc_en_n, tgt_clk});
        end
        halt_en = 1'b0;
    endtask

    task automatic test_run_limit_step();
        int n, k, w;
        n = $urandom_range(2, 6);
        halt_en = 1'b0;
        run_base = proc_edges;
        issue_cmd(2'd1, 16'(n));
        total++;
        if (bus.halted !== 1'b0) begin
            bad++;
            $display("FAIL halted_clear_on_accept: got=%0b required=0", bus.halted);
        end
        k = 1;
        while (!tgt_clk && k < 50) begin
            tick();
            k++;
        end
        total++;
        if (k !== CD + 1) begin
            bad++;
            $display("FAIL run_first_edge: cycle=%0d required=%0d", k, CD + 1);
        end
        w = 0;
        while (bus.busy && w < 2000) begin
            tick();
            w++;
        end
        total++;
        if (proc_edges - run_base !== n) begin
            bad++;
            $display("FAIL run_limit_edges: got=%0d required=%0d", proc_edges - run_base, n);
        end
        total++;
        if ({bus.busy, bus.halted} !== 2'b00) begin
            bad++;
            $display("FAIL run_limit_status: busy,halted got=%b required=00", {bus.busy, bus.halted});
        end
        // STEP ignores run_cycles and gives one edge
        run_base = proc_edges;
        issue_cmd(2'd3, 16'd7);
        w = 0;
        while (bus.busy && w < 500) begin
            tick();
            w++;
        end
        total++;
        if (proc_edges - run_base !== 1) begin
            bad++;
            $display("FAIL step_edges: got=%0d required=1", proc_edges - run_base);
        end
        // STEP with halt already asserted: no edge, halted set
        halt_en = 1'b1;
        halt_after = 0;
        run_base = proc_edges;
        issue_cmd(2'd3, 16'd0);
        w = 0;
        while (bus.busy && w < 500) begin
            tick();
            w++;
        end
        total++;
        if ({proc_edges - run_base == 0, bus.halted} !== 2'b11) begin
            bad++;
            $display("FAIL step_halted: edges=%0d halted=%0b required edges=0 halted=1",
                     proc_edges - run_base, bus.halted);
        end
        halt_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int e0, w;
        logic [9:0] got;
        e0 = edges_all;
        issue_cmd(2'd0, 16'd0);
        w = 0;
        while (edges_all - e0 < 5 && w < 1000) begin
            bus.tx_valid = bus.tx_ready;
            bus.tx_data = 8'($urandom_range(0, 255));
            bus.rx_ready = bus.rx_valid;
            tick();
            w++;
        end
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        got = {bus.cmd_ready, bus.busy, bus.halted, bus.tx_ready, bus.rx_valid,
               tgt_clk, tgt_rst, tgt_scan_en_n, tgt_proc_en_n, tgt_mosi};
        total++;
        if (got !== 10'b1000000110) begin
            bad++;
            $display("FAIL midscan_reset_flags: got=%b required=%b", got, 10'b1000000110);
        end
        total++;
        if ({dbg_state, bus.rx_data} !== 11'd0) begin
            bad++;
            $display("FAIL midscan_reset_state: state=%0d rx_data=%h required 0/00", dbg_state, bus.rx_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_treset();
        int e0, rh, en_bad, w;
        e0 = edges_all;
        rh = 0; en_bad = 0; w = 0;
        issue_cmd(2'd2, 16'd0);
        while (bus.busy && w < 500) begin
            if (tgt_rst) rh++;
            if (!tgt_scan_en_n || !tgt_proc_en_n) en_bad++;
            tick();
            w++;
        end
        total++;
        if (rh !== 4 * CD) begin
            bad++;
            $display("FAIL treset_len: got=%0d required=%0d", rh, 4 * CD);
        end
        total++;
        if (edges_all - e0 !== 2) begin
            bad++;
            $display("FAIL treset_edges: got=%0d required=2", edges_all - e0);
        end
        total++;
        if ({tgt_rst, tgt_clk, en_bad != 0} !== 3'b000) begin
            bad++;
            $display("FAIL treset_exit: rst,clk,en_bad got=%b required=000", {tgt_rst, tgt_clk, en_bad != 0});
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (excl_viol !== 0) begin
            bad++;
            $display("FAIL enable_exclusive: overlap cycles=%0d required=0", excl_viol);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.cmd = 2'd0;
        bus.cmd_valid = 1'b0;
        bus.run_cycles = 16'd0;
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        test_reset();
        test_scan_random();
        test_partial_byte();
        test_backpressure();
        test_run_halt();
        test_run_limit_step();
        test_reset_mid_scan();
        test_treset();
        test_scan_random();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
